// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants, opcodes, states and instruction fields for the accumulator CPU
// Contents: default widths, opcode encodings, sequencer state enumeration,
//           instruction field positions.
package cpu_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 6;

    localparam logic [1:0] OP_NOR = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_STA = 2'b10;
    localparam logic [1:0] OP_JCC = 2'b11;

    // Instruction layout: [15:14] opcode, [13:6] ignored, [5:0] operand address
    localparam int OPC_HI  = 15;
    localparam int OPC_LO  = 14;
    localparam int ADDR_LO = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_IRLD,
        ST_DECODE,
        ST_MEM_RD,
        ST_EXEC,
        ST_STORE,
        ST_HALT
    } state_e;

endpackage

// File: rtl/cpu_alu.sv
// rtl/cpu_alu.sv - combinational ALU for NOR and ADD
// Ports: op (opcode), acc, operand -> result, carry_out (ADD carry, 0 for NOR)
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] operand,
    output logic [DATA_W-1:0] result,
    output logic              carry_out
);

    logic [DATA_W:0] sum;

    assign sum = {1'b0, acc} + {1'b0, operand};

    always_comb begin
        result    = sum[DATA_W-1:0];
        carry_out = sum[DATA_W];
        if (op == OP_NOR) begin
            result    = ~(acc | operand);
            carry_out = 1'b0;
        end
    end

endmodule

// File: rtl/cpu_control_unit.sv
// rtl/cpu_control_unit.sv - fetch/decode/execute sequencer driving the program/data RAM
// Ports: clk, rst (async active-high), ce (global enable), ram_data_out (registered RAM read data)
//        -> ram_add, ram_data_in, ram_r_w, ram_enable, ram_ce, acc, pc, carry, halted
module cpu_control_unit
    import cpu_pkg::*;
#(
    parameter int                DATA_W   = DEF_DATA_W,
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic [DATA_W-1:0] ram_data_out,
    output logic [ADDR_W-1:0] ram_add,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_r_w,
    output logic              ram_enable,
    output logic              ram_ce,
    output logic [DATA_W-1:0] acc,
    output logic [ADDR_W-1:0] pc,
    output logic              carry,
    output logic              halted
);

    localparam logic [ADDR_W-1:0] PC_ONE = 1;

    state_e            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [DATA_W-1:0] ir_q;
    logic [DATA_W-1:0] acc_q;
    logic              carry_q;
    logic              halted_q;

    logic [ADDR_W-1:0] pc_inc_d;
    logic [ADDR_W-1:0] pc_prev;
    logic [1:0]        ir_op;
    logic [ADDR_W-1:0] ir_addr;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;
    logic              ir_unused;

    assign ir_op     = ir_q[OPC_HI:OPC_LO];
    assign ir_addr   = ir_q[ADDR_LO +: ADDR_W];
    assign ir_unused = ^ir_q[OPC_LO-1:ADDR_W];

    // pc is already incremented by DECODE, so the JCC's own address is pc-1
    assign pc_inc_d = pc_q + PC_ONE;
    assign pc_prev  = pc_q - PC_ONE;

    cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .op        (ir_op),
        .acc       (acc_q),
        .operand   (ram_data_out),
        .result    (alu_result),
        .carry_out (alu_carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            acc_q    <= '0;
            carry_q  <= 1'b0;
            halted_q <= 1'b0;
        end else if (ce) begin
            case (state_q)
                ST_IDLE:  state_q <= ST_FETCH;
                ST_FETCH: state_q <= ST_IRLD;
                ST_IRLD: begin
                    ir_q    <= ram_data_out;
                    pc_q    <= pc_inc_d;
                    state_q <= ST_DECODE;
                end
                ST_DECODE: begin
                    case (ir_op)
                        OP_NOR, OP_ADD: state_q <= ST_MEM_RD;
                        OP_STA:         state_q <= ST_STORE;
                        default: begin
                            if (carry_q) begin
                                carry_q <= 1'b0;
                                state_q <= ST_FETCH;
                            end else begin
                                pc_q <= ir_addr;
                                if (ir_addr == pc_prev) begin
                                    state_q  <= ST_HALT;
                                    halted_q <= 1'b1;
                                end else begin
                                    state_q <= ST_FETCH;
                                end
                            end
                        end
                    endcase
                end
                ST_MEM_RD: state_q <= ST_EXEC;
                ST_EXEC: begin
                    acc_q <= alu_result;
                    if (ir_op == OP_ADD) begin
                        carry_q <= alu_carry;
                    end
                    state_q <= ST_FETCH;
                end
                ST_STORE: state_q <= ST_FETCH;
                ST_HALT:  state_q <= ST_HALT;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    // Moore decode of the registered state; async reset of state_q drops
    // enable/r_w immediately, so a reset during STORE cannot commit a write.
    always_comb begin
        ram_add    = pc_q;
        ram_r_w    = 1'b0;
        ram_enable = 1'b0;
        case (state_q)
            ST_FETCH: ram_enable = 1'b1;
            ST_MEM_RD: begin
                ram_add    = ir_addr;
                ram_enable = 1'b1;
            end
            ST_STORE: begin
                ram_add    = ir_addr;
                ram_r_w    = 1'b1;
                ram_enable = 1'b1;
            end
            default: ;
        endcase
    end

    assign ram_data_in = acc_q;
    assign ram_ce      = ce;
    assign acc         = acc_q;
    assign pc          = pc_q;
    assign carry       = carry_q;
    assign halted      = halted_q;

endmodule
